// File: rtl/alb_pkg.sv
// Shared constants for the ALB command sequencer: opcodes, carry-in selects,
// FSM state encoding and flag bit positions.
package alb_pkg;

  localparam logic [2:0] OP_SUB = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;

  localparam logic [1:0] CS_ZERO  = 2'b00;
  localparam logic [1:0] CS_ONE   = 2'b01;
  localparam logic [1:0] CS_FLAGC = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Select code 11 falls back to a zero carry-in.
  function automatic logic ci_select(input logic [1:0] csel, input logic flag_c);
    logic ci;
    case (csel)
      CS_ONE:   ci = 1'b1;
      CS_FLAGC: ci = flag_c;
      default:  ci = 1'b0;
    endcase
    return ci;
  endfunction

endpackage

// File: rtl/alb_regfile.sv
// Small register file: synchronous write port, three combinational read ports
// (two operand sources plus a debug tap).
module alb_regfile #(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [1:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [1:0]   ra_addr,
  input  logic [1:0]   rb_addr,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] ra_data,
  output logic [W-1:0] rb_data,
  output logic [W-1:0] dbg_data
);

  logic [W-1:0] mem_q [NREG];
  logic [W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alb_op_sequencer.sv
// Command-driven control unit for the combinational ALB: latches operands,
// drives the ALB for one cycle, writes back the result and flags.
module alb_op_sequencer
  import alb_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CMD_VALID,
  output logic         CMD_READY,
  input  logic [2:0]   CMD_OP,
  input  logic [1:0]   CMD_DST,
  input  logic [1:0]   CMD_SA,
  input  logic [1:0]   CMD_SB,
  input  logic [1:0]   CMD_CSEL,
  input  logic [W-1:0] CMD_IMM,
  output logic [W-1:0] MR,
  output logic [W-1:0] MS,
  output logic         CI,
  output logic [2:0]   ALB_MI,
  input  logic [W-1:0] F_ALB,
  input  logic         CO,
  input  logic         VO,
  input  logic         NO,
  input  logic         ZO,
  output logic         RES_VALID,
  output logic [W-1:0] RES_DATA,
  output logic         RES_ERR,
  output logic [3:0]   FLAGS,
  input  logic [1:0]   DBG_SEL,
  output logic [W-1:0] DBG_DATA
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] mr_q, mr_d;
  logic [W-1:0] ms_q, ms_d;
  logic         ci_q, ci_d;
  logic [2:0]   mi_q, mi_d;
  logic [1:0]   dst_q, dst_d;
  logic [3:0]   flags_q, flags_d;
  logic         res_valid_q, res_valid_d;
  logic         res_err_q, res_err_d;
  logic [W-1:0] res_data_q, res_data_d;

  logic         rf_we;
  logic [1:0]   rf_waddr;
  logic [W-1:0] rf_wdata;
  logic [W-1:0] ra_data, rb_data;

  alb_regfile #(.W(W), .NREG(NREG)) u_regfile (
    .clk      (CLK),
    .rst      (RST),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (CMD_SA),
    .rb_addr  (CMD_SB),
    .dbg_addr (DBG_SEL),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (DBG_DATA)
  );

  // Operands are captured at accept so a write to DST cannot disturb them.
  always_comb begin
    state_d     = state_q;
    mr_d        = mr_q;
    ms_d        = ms_q;
    ci_d        = ci_q;
    mi_d        = mi_q;
    dst_d       = dst_q;
    flags_d     = flags_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_data_d  = res_data_q;
    rf_we       = 1'b0;
    rf_waddr    = CMD_DST;
    rf_wdata    = CMD_IMM;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          if (!CMD_OP[2]) begin
            mr_d    = ra_data;
            ms_d    = rb_data;
            mi_d    = CMD_OP;
            ci_d    = ci_select(CMD_CSEL, flags_q[FLAG_C]);
            dst_d   = CMD_DST;
            state_d = ST_ISSUE;
          end else begin
            res_valid_d = 1'b1;
            state_d     = ST_WB;
            if (CMD_OP == OP_LDI) begin
              rf_we      = 1'b1;
              res_data_d = CMD_IMM;
              res_err_d  = 1'b0;
            end else begin
              res_err_d = 1'b1;
            end
          end
        end
      end
      ST_ISSUE: begin
        rf_we       = 1'b1;
        rf_waddr    = dst_q;
        rf_wdata    = F_ALB;
        flags_d     = {CO, VO, NO, ZO};
        res_data_d  = F_ALB;
        res_valid_d = 1'b1;
        res_err_d   = 1'b0;
        state_d     = ST_WB;
      end
      ST_WB: begin
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        res_valid_d = 1'b0;
        res_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mr_q        <= '0;
      ms_q        <= '0;
      ci_q        <= 1'b0;
      mi_q        <= '0;
      dst_q       <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mr_q        <= mr_d;
      ms_q        <= ms_d;
      ci_q        <= ci_d;
      mi_q        <= mi_d;
      dst_q       <= dst_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
    end
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign MR        = mr_q;
  assign MS        = ms_q;
  assign CI        = ci_q;
  assign ALB_MI    = mi_q;
  assign FLAGS     = flags_q;
  assign RES_VALID = res_valid_q;
  assign RES_ERR   = res_err_q;
  assign RES_DATA  = res_data_q;

endmodule

// File: tb/tb_alb_op_sequencer.sv
// Bench for alb_op_sequencer: a stand-in combinational ALB, a transaction-level
// model of the sequencer, directed literal checks and randomized commands.
module tb_alb_op_sequencer;
  import alb_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [1:0] CMD_DST, CMD_SA, CMD_SB, CMD_CSEL;
  logic [3:0] CMD_IMM;
  logic [3:0] MR, MS;
  logic       CI;
  logic [2:0] ALB_MI;
  logic [3:0] F_ALB;
  logic       CO, VO, NO, ZO;
  logic       RES_VALID;
  logic [3:0] RES_DATA;
  logic       RES_ERR;
  logic [3:0] FLAGS;
  logic [1:0] DBG_SEL;
  logic [3:0] DBG_DATA;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alb_op_sequencer #(.W(4), .NREG(4)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_DST(CMD_DST), .CMD_SA(CMD_SA), .CMD_SB(CMD_SB),
    .CMD_CSEL(CMD_CSEL), .CMD_IMM(CMD_IMM),
    .MR(MR), .MS(MS), .CI(CI), .ALB_MI(ALB_MI),
    .F_ALB(F_ALB), .CO(CO), .VO(VO), .NO(NO), .ZO(ZO),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
    .FLAGS(FLAGS), .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA)
  );

  // ALB behaviour: returns {C,V,N,Z,F}.
  function automatic logic [7:0] alb_calc(input logic [2:0] mi, input logic [3:0] r,
                                          input logic [3:0] s, input logic cin);
    logic [4:0] sum;
    logic [3:0] f;
    logic c, v;
    sum = 5'd0;
    f = 4'd0;
    c = 1'b0;
    v = 1'b0;
    case (mi)
      OP_ADD: begin
        sum = {1'b0, r} + {1'b0, s} + {4'd0, cin};
        f = sum[3:0]; c = sum[4];
        v = (r[3] == s[3]) && (f[3] != r[3]);
      end
      OP_SUB: begin
        sum = {1'b0, r} + {1'b0, ~s} + {4'd0, cin};
        f = sum[3:0]; c = sum[4];
        v = (r[3] != s[3]) && (f[3] != r[3]);
      end
      OP_AND: f = r & s;
      OP_OR:  f = r | s;
      default: f = 4'd0;
    endcase
    return {c, v, f[3], (f == 4'd0), f};
  endfunction

  always_comb {CO, VO, NO, ZO, F_ALB} = alb_calc(ALB_MI, MR, MS, CI);

  // Transaction-level model of the sequencer.
  logic [3:0] m_reg [4];
  logic [3:0] m_flags, m_res_data, m_mr, m_ms;
  logic       m_ci, m_valid, m_err, m_pend;
  logic [2:0] m_mi;
  logic [1:0] m_dst;
  logic [7:0] m_pend_res;
  int         m_busy;
  logic       chk_en = 1'b0;

  function automatic logic modelReady();
    return !m_pend && (m_busy == 0);
  endfunction

  task automatic modelStep();
    logic nv, ne;
    nv = 1'b0;
    ne = 1'b0;
    if (RST) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
      m_flags = 4'd0; m_res_data = 4'd0; m_mr = 4'd0; m_ms = 4'd0;
      m_ci = 1'b0; m_mi = 3'd0; m_dst = 2'd0; m_pend = 1'b0; m_busy = 0;
      m_pend_res = 8'd0;
    end else if (m_pend) begin
      m_reg[m_dst] = m_pend_res[3:0];
      m_flags      = m_pend_res[7:4];
      m_res_data   = m_pend_res[3:0];
      nv = 1'b1;
      m_pend = 1'b0;
      m_busy = 1;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (CMD_VALID) begin
      if (CMD_OP < 3'd4) begin
        m_mr  = m_reg[CMD_SA];
        m_ms  = m_reg[CMD_SB];
        m_mi  = CMD_OP;
        m_ci  = (CMD_CSEL == 2'b01) ? 1'b1 : (CMD_CSEL == 2'b10) ? m_flags[3] : 1'b0;
        m_dst = CMD_DST;
        m_pend_res = alb_calc(m_mi, m_mr, m_ms, m_ci);
        m_pend = 1'b1;
      end else if (CMD_OP == 3'd4) begin
        m_reg[CMD_DST] = CMD_IMM;
        m_res_data = CMD_IMM;
        nv = 1'b1;
        m_busy = 1;
      end else begin
        nv = 1'b1;
        ne = 1'b1;
        m_busy = 1;
      end
    end
    m_valid = nv;
    m_err   = ne;
  endtask

  initial forever begin
    @(posedge CLK);
    modelStep();
  end

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, well clear of the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      #2;
      checkOutput("cmd_ready", {7'd0, CMD_READY}, {7'd0, modelReady()});
      checkOutput("res_valid", {7'd0, RES_VALID}, {7'd0, m_valid});
      checkOutput("res_err",   {7'd0, RES_ERR},   {7'd0, m_err});
      checkOutput("res_data",  {4'd0, RES_DATA},  {4'd0, m_res_data});
      checkOutput("flags",     {4'd0, FLAGS},     {4'd0, m_flags});
      checkOutput("mr",        {4'd0, MR},        {4'd0, m_mr});
      checkOutput("ms",        {4'd0, MS},        {4'd0, m_ms});
      checkOutput("ci",        {7'd0, CI},        {7'd0, m_ci});
      checkOutput("alb_mi",    {5'd0, ALB_MI},    {5'd0, m_mi});
      checkOutput("dbg_data",  {4'd0, DBG_DATA},  {4'd0, m_reg[DBG_SEL]});
    end
  end

  // Drives one command and returns at the falling edge after the accept edge
  // (plus 'hold' extra falling edges with CMD_VALID still high).
  task automatic applyStimulus(input logic [2:0] op, input logic [1:0] dst,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] csel, input logic [3:0] imm,
                               input int hold);
    bit got;
    @(negedge CLK);
    CMD_OP = op; CMD_DST = dst; CMD_SA = sa; CMD_SB = sb;
    CMD_CSEL = csel; CMD_IMM = imm; CMD_VALID = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (modelReady()) begin
        @(posedge CLK);
        got = 1'b1;
      end else begin
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    if (!got) checkOutput("accept_timeout", 8'd0, 8'd1);
    repeat (hold) @(negedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_DST = 2'd0; CMD_SA = 2'd0;
    CMD_SB = 2'd0; CMD_CSEL = 2'd0; CMD_IMM = 4'd0; DBG_SEL = 2'd0;
    @(posedge CLK);
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #3;
    checkOutput("rst_ready", {7'd0, CMD_READY}, 8'd1);
    checkOutput("rst_valid", {7'd0, RES_VALID}, 8'd0);
    checkOutput("rst_flags", {4'd0, FLAGS}, 8'h00);
    RST = 1'b0;

    applyStimulus(OP_LDI, 2'd0, 2'd0, 2'd0, 2'b00, 4'b0110, 0); #3;
    checkOutput("ldi0_valid", {7'd0, RES_VALID}, 8'd1);
    checkOutput("ldi0_data", {4'd0, RES_DATA}, 8'h06);
    applyStimulus(OP_LDI, 2'd1, 2'd0, 2'd0, 2'b00, 4'b0011, 0); #3;
    checkOutput("ldi1_data", {4'd0, RES_DATA}, 8'h03);
    @(negedge CLK); DBG_SEL = 2'd0; #3;
    checkOutput("dbg_r0", {4'd0, DBG_DATA}, 8'h06);
    checkOutput("valid_one_cycle", {7'd0, RES_VALID}, 8'd0);
    @(negedge CLK); DBG_SEL = 2'd1; #3;
    checkOutput("dbg_r1", {4'd0, DBG_DATA}, 8'h03);
    checkOutput("ldi_flags", {4'd0, FLAGS}, 8'h00);

    applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd1, 2'b01, 4'd0, 0); #3;
    checkOutput("add_mr", {4'd0, MR}, 8'h06);
    checkOutput("add_ms", {4'd0, MS}, 8'h03);
    checkOutput("add_ci", {7'd0, CI}, 8'd1);
    checkOutput("add_mi", {5'd0, ALB_MI}, 8'h03);
    checkOutput("add_early_valid", {7'd0, RES_VALID}, 8'd0);
    @(negedge CLK); #3;
    checkOutput("add_valid", {7'd0, RES_VALID}, 8'd1);
    checkOutput("add_data", {4'd0, RES_DATA}, 8'h0a);
    checkOutput("add_flags", {4'd0, FLAGS}, 8'h06);

    applyStimulus(OP_LDI, 2'd0, 2'd0, 2'd0, 2'b00, 4'b1111, 0);
    applyStimulus(OP_LDI, 2'd1, 2'd0, 2'd0, 2'b00, 4'b0001, 0);
    applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd1, 2'b01, 4'd0, 0);
    @(negedge CLK); #3;
    checkOutput("carry_data", {4'd0, RES_DATA}, 8'h01);
    checkOutput("carry_c", {7'd0, FLAGS[FLAG_C]}, 8'd1);
    applyStimulus(OP_ADD, 2'd3, 2'd1, 2'd1, 2'b10, 4'd0, 0); #3;
    checkOutput("flagc_ci", {7'd0, CI}, 8'd1);
    @(negedge CLK); #3;
    checkOutput("flagc_data", {4'd0, RES_DATA}, 8'h03);

    applyStimulus(OP_LDI, 2'd0, 2'd0, 2'd0, 2'b00, 4'b0101, 0);
    applyStimulus(OP_SUB, 2'd3, 2'd0, 2'd0, 2'b01, 4'd0, 0);
    @(negedge CLK); #3;
    checkOutput("sub_data", {4'd0, RES_DATA}, 8'h00);
    checkOutput("sub_flags", {4'd0, FLAGS}, 8'h09);

    applyStimulus(OP_LDI, 2'd0, 2'd0, 2'd0, 2'b00, 4'b0110, 0);
    applyStimulus(OP_LDI, 2'd1, 2'd0, 2'd0, 2'b00, 4'b0011, 0);
    applyStimulus(OP_AND, 2'd2, 2'd0, 2'd1, 2'b00, 4'd0, 0);
    @(negedge CLK); #3;
    checkOutput("and_data", {4'd0, RES_DATA}, 8'h02);
    applyStimulus(OP_OR, 2'd3, 2'd0, 2'd1, 2'b00, 4'd0, 2);
    checkOutput("or_data", {4'd0, RES_DATA}, 8'h07);

    applyStimulus(3'b110, 2'd0, 2'd0, 2'd0, 2'b00, 4'hc, 0); #3;
    checkOutput("rsv_valid", {7'd0, RES_VALID}, 8'd1);
    checkOutput("rsv_err", {7'd0, RES_ERR}, 8'd1);
    checkOutput("rsv_data", {4'd0, RES_DATA}, 8'h07);
    checkOutput("rsv_flags", {4'd0, FLAGS}, 8'h00);
    DBG_SEL = 2'd0; #1;
    checkOutput("rsv_r0", {4'd0, DBG_DATA}, 8'h06);

    applyStimulus(OP_ADD, 2'd2, 2'd0, 2'd1, 2'b01, 4'd0, 0);
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0; DBG_SEL = 2'd2; #3;
    checkOutput("mid_rst_r2", {4'd0, DBG_DATA}, 8'h00);
    checkOutput("mid_rst_valid", {7'd0, RES_VALID}, 8'd0);
    checkOutput("mid_rst_mr", {4'd0, MR}, 8'h00);
    checkOutput("mid_rst_ready", {7'd0, CMD_READY}, 8'd1);

    for (int n = 0; n < 250; n++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rop = OP_LDI;
      DBG_SEL = 2'($urandom);
      applyStimulus(rop, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    4'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
